vga_screen_mux: RTL and testbench

- Parametrised N-source VGA stream selector; successor of the game-state screen selector.
- Sits between the per-screen draw pipelines (start, keeper, shooter, end, ...) and the VGA output stage.
- Switches screens only on frame boundaries, with an optional blanking interval, so the display never shows a torn or partial frame.
- Selection request comes from the game control logic as a source index.

---
 rtl/vga_screen_mux_if.sv | 40 ++++
 rtl/vga_screen_mux.sv | 180 ++++++++++++++++++
 tb/tb_vga_screen_mux.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_screen_mux_if.sv
// Source/output bus of the N-source VGA screen selector.
// slave = the selector itself, master = the surrounding game/VGA logic.
interface vga_screen_mux_if #(
    parameter int N_SRC = 5,
    parameter int SEL_W = $clog2(N_SRC),
    parameter int RGB_W = 12,
    parameter int CNT_W = 11
);
    logic [N_SRC*CNT_W-1:0] src_hcount;
    logic [N_SRC*CNT_W-1:0] src_vcount;
    logic [N_SRC-1:0]       src_hsync;
    logic [N_SRC-1:0]       src_vsync;
    logic [N_SRC-1:0]       src_hblnk;
    logic [N_SRC-1:0]       src_vblnk;
    logic [N_SRC*RGB_W-1:0] src_rgb;
    logic [SEL_W-1:0]       sel_req;

    logic [CNT_W-1:0]       out_hcount;
    logic [CNT_W-1:0]       out_vcount;
    logic                   out_hsync;
    logic                   out_vsync;
    logic                   out_hblnk;
    logic                   out_vblnk;
    logic [RGB_W-1:0]       out_rgb;
    logic [SEL_W-1:0]       active_sel;
    logic                   switch_done;
    logic                   busy;

    modport master (
        output src_hcount, src_vcount, src_hsync, src_vsync, src_hblnk, src_vblnk, src_rgb, sel_req,
        input  out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb,
        input  active_sel, switch_done, busy
    );

    modport slave (
        input  src_hcount, src_vcount, src_hsync, src_vsync, src_hblnk, src_vblnk, src_rgb, sel_req,
        output out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb,
        output active_sel, switch_done, busy
    );
endinterface

// File: rtl/vga_screen_mux.sv
// N-source VGA stream selector switching only on frame boundaries, with optional black frames.
// Define SCREEN_MUX_FADE_EN to fade the outgoing source during the blank frames instead of hard black.
module vga_screen_mux #(
    parameter int N_SRC        = 5,
    parameter int SEL_W        = $clog2(N_SRC),
    parameter int RGB_W        = 12,
    parameter int CNT_W        = 11,
    parameter int BLANK_FRAMES = 1,
    parameter int RESET_SEL    = 0
) (
    input  logic            clk,
    input  logic            rst,
    vga_screen_mux_if.slave bus
);
    localparam int CH_W = RGB_W / 3;
    localparam int FC_W = (BLANK_FRAMES > 2) ? $clog2(BLANK_FRAMES) : 1;
    localparam logic [FC_W-1:0]  LAST_CNT = (BLANK_FRAMES > 0) ? FC_W'(BLANK_FRAMES - 1) : '0;
    localparam logic [SEL_W:0]   SRC_LIM  = (SEL_W + 1)'(N_SRC);

    typedef enum logic [1:0] {S_STABLE, S_PENDING, S_BLANK} state_t;

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_active, w_active_nxt;
    logic [SEL_W-1:0] r_tgt, w_tgt_nxt;
    logic [FC_W-1:0]  r_cnt, w_cnt_nxt;
    logic             w_switch, w_fb, w_req_ok, w_busy;

    logic [CNT_W-1:0] w_hc_act, w_vc_act;
    logic [CNT_W-1:0] w_hc, w_vc;
    logic             w_hs, w_vs, w_hb, w_vb;
    logic [RGB_W-1:0] w_rgb, w_rgb_out;
`ifdef SCREEN_MUX_FADE_EN
    logic [FC_W:0]    w_shift;
`endif

    logic [CNT_W-1:0] r_hcount, r_vcount;
    logic             r_hsync, r_vsync, r_hblnk, r_vblnk, r_done;
    logic [RGB_W-1:0] r_rgb;

    // The frame boundary is judged on the current source; the output register
    // already follows the next source so the switch lands on the first pixel.
    always_comb begin
        w_hc_act = '0;
        w_vc_act = '0;
        w_hc     = '0;
        w_vc     = '0;
        w_hs     = 1'b0;
        w_vs     = 1'b0;
        w_hb     = 1'b0;
        w_vb     = 1'b0;
        w_rgb    = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (r_active == SEL_W'(i)) begin
                w_hc_act = bus.src_hcount[i*CNT_W +: CNT_W];
                w_vc_act = bus.src_vcount[i*CNT_W +: CNT_W];
            end
            if (w_active_nxt == SEL_W'(i)) begin
                w_hc  = bus.src_hcount[i*CNT_W +: CNT_W];
                w_vc  = bus.src_vcount[i*CNT_W +: CNT_W];
                w_hs  = bus.src_hsync[i];
                w_vs  = bus.src_vsync[i];
                w_hb  = bus.src_hblnk[i];
                w_vb  = bus.src_vblnk[i];
                w_rgb = bus.src_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    assign w_fb     = (w_hc_act == '0) && (w_vc_act == '0);
    assign w_req_ok = ({1'b0, bus.sel_req} < SRC_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_STABLE;
            r_active <= SEL_W'(RESET_SEL);
            r_tgt    <= SEL_W'(RESET_SEL);
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_tgt    <= w_tgt_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_tgt_nxt    = r_tgt;
        w_cnt_nxt    = r_cnt;
        w_switch     = 1'b0;
        unique case (r_state)
            S_STABLE: begin
                if (w_req_ok && (bus.sel_req != r_active)) begin
                    w_tgt_nxt   = bus.sel_req;
                    w_state_nxt = S_PENDING;
                end
            end
            S_PENDING: begin
                // A boundary wins over a same-cycle request change.
                if (w_fb) begin
                    if (BLANK_FRAMES == 0) begin
                        w_active_nxt = r_tgt;
                        w_switch     = 1'b1;
                        w_state_nxt  = S_STABLE;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_BLANK;
                    end
                end else if (bus.sel_req == r_active) begin
                    w_state_nxt = S_STABLE;
                end else if (w_req_ok) begin
                    w_tgt_nxt = bus.sel_req;
                end
            end
            S_BLANK: begin
                if (w_fb) begin
                    if (r_cnt == LAST_CNT) begin
                        w_active_nxt = r_tgt;
                        w_switch     = 1'b1;
                        w_state_nxt  = S_STABLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_STABLE;
        endcase
    end

    always_comb begin
        w_busy    = (r_state != S_STABLE);
        w_rgb_out = w_rgb;
`ifdef SCREEN_MUX_FADE_EN
        w_shift   = {1'b0, w_cnt_nxt} + 1'b1;
        if (w_state_nxt == S_BLANK) begin
            for (int unsigned c = 0; c < 3; c++) begin
                w_rgb_out[c*CH_W +: CH_W] = w_rgb[c*CH_W +: CH_W] >> w_shift;
            end
        end
`else
        if (w_state_nxt == S_BLANK) begin
            w_rgb_out = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_hblnk  <= 1'b0;
            r_vblnk  <= 1'b0;
            r_rgb    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_hcount <= w_hc;
            r_vcount <= w_vc;
            r_hsync  <= w_hs;
            r_vsync  <= w_vs;
            r_hblnk  <= w_hb;
            r_vblnk  <= w_vb;
            r_rgb    <= w_rgb_out;
            r_done   <= w_switch;
        end
    end

    assign bus.out_hcount  = r_hcount;
    assign bus.out_vcount  = r_vcount;
    assign bus.out_hsync   = r_hsync;
    assign bus.out_vsync   = r_vsync;
    assign bus.out_hblnk   = r_hblnk;
    assign bus.out_vblnk   = r_vblnk;
    assign bus.out_rgb     = r_rgb;
    assign bus.active_sel  = r_active;
    assign bus.switch_done = r_done;
    assign bus.busy        = w_busy;
endmodule

// File: tb/tb_vga_screen_mux.sv
// Bench for vga_screen_mux: a direct-switch instance and a two-blank-frame instance share one
// set of synchronised sources and are checked every cycle against a frame-number based model.
module tb_vga_screen_mux;
    localparam int N  = 5;
    localparam int SW = 3;
    localparam int HT = 16;
    localparam int VT = 8;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [SW-1:0] sel_req = '0;
    logic [10:0] h_cnt = '0;
    logic [10:0] v_cnt = '0;
    logic [11:0] src_col [N];
    logic hs, vs, hb, vb;

    logic [N*11-1:0] w_src_hc, w_src_vc;
    logic [N*12-1:0] w_src_rgb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vga_screen_mux_if #(.N_SRC(N), .SEL_W(SW), .RGB_W(12), .CNT_W(11)) bus0 ();
    vga_screen_mux_if #(.N_SRC(N), .SEL_W(SW), .RGB_W(12), .CNT_W(11)) bus2 ();

    vga_screen_mux #(.N_SRC(N), .SEL_W(SW), .RGB_W(12), .CNT_W(11), .BLANK_FRAMES(0), .RESET_SEL(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    vga_screen_mux #(.N_SRC(N), .SEL_W(SW), .RGB_W(12), .CNT_W(11), .BLANK_FRAMES(2), .RESET_SEL(0))
        dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    // Shared small-raster timing: 16x8 pixels per frame, every source in lock-step.
    always @(negedge clk) begin
        if (h_cnt == 11'(HT - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == 11'(VT - 1)) ? '0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign hb = (h_cnt >= 11'd12);
    assign hs = (h_cnt >= 11'd13) && (h_cnt <= 11'd14);
    assign vb = (v_cnt >= 11'd6);
    assign vs = (v_cnt == 11'd7);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_src_hc[i*11 +: 11]  = h_cnt;
            w_src_vc[i*11 +: 11]  = v_cnt;
            w_src_rgb[i*12 +: 12] = src_col[i];
        end
    end

    assign bus0.src_hcount = w_src_hc;
    assign bus0.src_vcount = w_src_vc;
    assign bus0.src_hsync  = {N{hs}};
    assign bus0.src_vsync  = {N{vs}};
    assign bus0.src_hblnk  = {N{hb}};
    assign bus0.src_vblnk  = {N{vb}};
    assign bus0.src_rgb    = w_src_rgb;
    assign bus0.sel_req    = sel_req;
    assign bus2.src_hcount = w_src_hc;
    assign bus2.src_vcount = w_src_vc;
    assign bus2.src_hsync  = {N{hs}};
    assign bus2.src_vsync  = {N{vs}};
    assign bus2.src_hblnk  = {N{hb}};
    assign bus2.src_vblnk  = {N{vb}};
    assign bus2.src_rgb    = w_src_rgb;
    assign bus2.sel_req    = sel_req;

    logic [42:0] obs0, obs2, exp0, exp2;
    assign obs0 = {bus0.out_hcount, bus0.out_vcount, bus0.out_hsync, bus0.out_vsync, bus0.out_hblnk,
                   bus0.out_vblnk, bus0.out_rgb, bus0.active_sel, bus0.switch_done, bus0.busy};
    assign obs2 = {bus2.out_hcount, bus2.out_vcount, bus2.out_hsync, bus2.out_vsync, bus2.out_hblnk,
                   bus2.out_vblnk, bus2.out_rgb, bus2.active_sel, bus2.switch_done, bus2.busy};

    // Reference model: a request seen mid-frame F takes effect at the start of frame F+1+bf;
    // frames F+1 .. F+bf are blanked (faded when enabled). Tracked by absolute frame number.
    int          frame_no = 0;
    int          m_sel [2];
    int          m_tgt [2];
    int          m_sw  [2];
    bit          m_pend [2];
    logic [25:0] e_tim;
    logic [11:0] e_rgb  [2];
    logic [2:0]  e_sel  [2];
    logic        e_done [2];
    logic        e_busy [2];

    assign exp0 = {e_tim, e_rgb[0], e_sel[0], e_done[0], e_busy[0]};
    assign exp2 = {e_tim, e_rgb[1], e_sel[1], e_done[1], e_busy[1]};

    always @(posedge clk or posedge rst) begin : model
        int fcur, sel, tgt, sw, sh, bf, req;
        bit pend, fb, blank, done;
        logic [11:0] col;
        if (rst) begin
            e_tim <= '0;
            for (int k = 0; k < 2; k++) begin
                e_rgb[k]  <= '0;
                e_sel[k]  <= '0;
                e_done[k] <= 1'b0;
                e_busy[k] <= 1'b0;
                m_sel[k]  <= 0;
                m_tgt[k]  <= 0;
                m_sw[k]   <= -1;
                m_pend[k] <= 1'b0;
            end
        end else begin
            fb   = (h_cnt == 11'd0) && (v_cnt == 11'd0);
            fcur = fb ? frame_no + 1 : frame_no;
            req  = int'(sel_req);
            frame_no <= fcur;
            e_tim <= {h_cnt, v_cnt, hs, vs, hb, vb};
            for (int k = 0; k < 2; k++) begin
                bf = (k == 0) ? 0 : 2;
                sel = m_sel[k]; tgt = m_tgt[k]; sw = m_sw[k]; pend = m_pend[k];
                done = 1'b0; blank = 1'b0; sh = 0;
                if (sw >= 0) begin
                    if (fcur == sw) begin
                        sel = tgt; sw = -1; done = 1'b1;
                    end else begin
                        blank = 1'b1; sh = fcur - (sw - bf) + 1;
                    end
                end else if (pend) begin
                    if (fb) begin
                        pend = 1'b0;
                        if (bf == 0) begin
                            sel = tgt; done = 1'b1;
                        end else begin
                            sw = fcur + bf; blank = 1'b1; sh = 1;
                        end
                    end else if (req == sel) begin
                        pend = 1'b0;
                    end else if (req < N) begin
                        tgt = req;
                    end
                end else if (req != sel && req < N) begin
                    pend = 1'b1; tgt = req;
                end
                col = src_col[sel];
                if (blank) begin
`ifdef SCREEN_MUX_FADE_EN
                    col = {col[11:8] >> sh, col[7:4] >> sh, col[3:0] >> sh};
`else
                    col = '0;
`endif
                end
                m_sel[k]  <= sel;
                m_tgt[k]  <= tgt;
                m_sw[k]   <= sw;
                m_pend[k] <= pend;
                e_rgb[k]  <= col;
                e_sel[k]  <= 3'(sel);
                e_done[k] <= done;
                e_busy[k] <= pend || (sw >= 0);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        sel_req = '0;
        repeat (3) begin
            @(negedge clk); #1;
            n_tests++; if (obs0 !== 43'd0) begin n_fail++; $display("FAIL reset_hold dut0 got=%h exp=0", obs0); end
            n_tests++; if (obs2 !== 43'd0) begin n_fail++; $display("FAIL reset_hold dut2 got=%h exp=0", obs2); end
        end
        rst = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (bus0.out_rgb !== 12'hF00 || bus0.active_sel !== 3'd0 || bus0.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release dut0 rgb=%h sel=%0d busy=%b exp rgb=f00 sel=0 busy=0",
                     bus0.out_rgb, bus0.active_sel, bus0.busy);
        end
        n_tests++;
        if (bus2.out_rgb !== 12'hF00 || bus2.active_sel !== 3'd0 || bus2.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release dut2 rgb=%h sel=%0d busy=%b exp rgb=f00 sel=0 busy=0",
                     bus2.out_rgb, bus2.active_sel, bus2.busy);
        end
        n_tests++; if (obs0 !== exp0) begin n_fail++; $display("FAIL reset_model dut0 got=%h exp=%h", obs0, exp0); end
        n_tests++; if (obs2 !== exp2) begin n_fail++; $display("FAIL reset_model dut2 got=%h exp=%h", obs2, exp2); end
    endtask

    task automatic test_direct_switch();
        int pulses = 0;
        for (int c = 0; c < 2 * FRAME && !(v_cnt == 11'd3 && h_cnt == 11'd5); c++) begin
            @(negedge clk); #1;
            n_tests++; if (obs0 !== exp0) begin n_fail++; $display("FAIL direct_wait dut0 t=%0t got=%h exp=%h", $time, obs0, exp0); end
            n_tests++; if (obs2 !== exp2) begin n_fail++; $display("FAIL direct_wait dut2 t=%0t got=%h exp=%h", $time, obs2, exp2); end
        end
        sel_req = 3'd2;
        for (int c = 0; c < 5 * FRAME; c++) begin
            @(negedge clk); #1;
            if (bus0.switch_done === 1'b1) pulses++;
            n_tests++; if (obs0 !== exp0) begin n_fail++; $display("FAIL direct dut0 t=%0t got=%h exp=%h", $time, obs0, exp0); end
            n_tests++; if (obs2 !== exp2) begin n_fail++; $display("FAIL direct dut2 t=%0t got=%h exp=%h", $time, obs2, exp2); end
        end
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL direct_pulses got=%0d exp=1", pulses); end
        n_tests++;
        if (bus0.active_sel !== 3'd2 || bus2.active_sel !== 3'd2 || bus2.out_rgb !== 12'h00F) begin
            n_fail++;
            $display("FAIL direct_final sel0=%0d sel2=%0d rgb2=%h exp 2 2 00f", bus0.active_sel, bus2.active_sel, bus2.out_rgb);
        end
    endtask

    task automatic test_cancel();
        int pulses = 0;
        for (int c = 0; c < 2 * FRAME && !(v_cnt == 11'd2 && h_cnt == 11'd0); c++) begin
            @(negedge clk); #1;
            n_tests++; if (obs0 !== exp0) begin n_fail++; $display("FAIL cancel_wait dut0 got=%h exp=%h", obs0, exp0); end
            n_tests++; if (obs2 !== exp2) begin n_fail++; $display("FAIL cancel_wait dut2 got=%h exp=%h", obs2, exp2); end
        end
        sel_req = 3'd1;
        repeat (10) begin
            @(negedge clk); #1;
            n_tests++; if (obs0 !== exp0) begin n_fail++; $display("FAIL cancel dut0 got=%h exp=%h", obs0, exp0); end
            n_tests++; if (obs2 !== exp2) begin n_fail++; $display("FAIL cancel dut2 got=%h exp=%h", obs2, exp2); end
        end
        sel_req = 3'd3;
        repeat (10) @(negedge clk);
        #1;
        n_tests++; if (bus0.busy !== 1'b1 || bus2.busy !== 1'b1) begin n_fail++; $display("FAIL cancel_busy_hi got=%b%b exp=11", bus0.busy, bus2.busy); end
        sel_req = 3'd2;
        @(negedge clk); #1;
        n_tests++; if (bus0.busy !== 1'b0 || bus2.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy_lo got=%b%b exp=00", bus0.busy, bus2.busy); end
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk); #1;
            if (bus0.switch_done === 1'b1 || bus2.switch_done === 1'b1) pulses++;
            n_tests++; if (obs0 !== exp0) begin n_fail++; $display("FAIL cancel_after dut0 got=%h exp=%h", obs0, exp0); end
            n_tests++; if (obs2 !== exp2) begin n_fail++; $display("FAIL cancel_after dut2 got=%h exp=%h", obs2, exp2); end
        end
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL cancel_pulses got=%0d exp=0", pulses); end
    endtask

    task automatic test_invalid();
        for (int c = 0; c < 3 * FRAME; c++) begin
            sel_req = 3'(5 + $urandom_range(0, 2));
            @(negedge clk); #1;
            n_tests++; if (obs0 !== exp0) begin n_fail++; $display("FAIL invalid dut0 got=%h exp=%h", obs0, exp0); end
            n_tests++; if (obs2 !== exp2) begin n_fail++; $display("FAIL invalid dut2 got=%h exp=%h", obs2, exp2); end
        end
        n_tests++;
        if (bus0.busy !== 1'b0 || bus2.busy !== 1'b0 || bus0.active_sel !== 3'd2 || bus0.out_rgb !== 12'h00F) begin
            n_fail++;
            $display("FAIL invalid_final busy=%b%b sel=%0d rgb=%h exp busy=00 sel=2 rgb=00f",
                     bus0.busy, bus2.busy, bus0.active_sel, bus0.out_rgb);
        end
    endtask

    task automatic test_random();
        src_col[3] = 12'($urandom);
        src_col[4] = 12'($urandom);
        repeat (30) begin
            int hold = $urandom_range(1, 300);
            sel_req = 3'($urandom_range(0, 7));
            for (int c = 0; c < hold; c++) begin
                @(negedge clk); #1;
                n_tests++; if (obs0 !== exp0) begin n_fail++; $display("FAIL random dut0 t=%0t got=%h exp=%h", $time, obs0, exp0); end
                n_tests++; if (obs2 !== exp2) begin n_fail++; $display("FAIL random dut2 t=%0t got=%h exp=%h", $time, obs2, exp2); end
            end
        end
    endtask

    task automatic test_fade();
        sel_req = 3'd0;
        for (int c = 0; c < 5 * FRAME; c++) begin
            @(negedge clk); #1;
            n_tests++; if (obs0 !== exp0) begin n_fail++; $display("FAIL fade_settle dut0 got=%h exp=%h", obs0, exp0); end
            n_tests++; if (obs2 !== exp2) begin n_fail++; $display("FAIL fade_settle dut2 got=%h exp=%h", obs2, exp2); end
        end
        src_col[0] = 12'hFFF;
        for (int c = 0; c < 2 * FRAME && !(v_cnt == 11'd3 && h_cnt == 11'd7); c++) @(negedge clk);
        #1;
        sel_req = 3'd1;
        for (int c = 0; c < 5 * FRAME; c++) begin
            @(negedge clk); #1;
            n_tests++; if (obs0 !== exp0) begin n_fail++; $display("FAIL fade dut0 t=%0t got=%h exp=%h", $time, obs0, exp0); end
            n_tests++; if (obs2 !== exp2) begin n_fail++; $display("FAIL fade dut2 t=%0t got=%h exp=%h", $time, obs2, exp2); end
        end
    endtask

    task automatic test_reset_mid_blank();
        sel_req = 3'd0;
        for (int c = 0; c < 5 * FRAME; c++) begin
            @(negedge clk); #1;
            n_tests++; if (obs2 !== exp2) begin n_fail++; $display("FAIL rstblank_settle dut2 got=%h exp=%h", obs2, exp2); end
        end
        for (int c = 0; c < 2 * FRAME && !(v_cnt == 11'd3 && h_cnt == 11'd1); c++) @(negedge clk);
        #1;
        sel_req = 3'd3;
        for (int c = 0; c < 2 * FRAME && !(v_cnt == 11'd0 && h_cnt == 11'd0); c++) @(negedge clk);
        for (int c = 0; c < 2 * FRAME && !(v_cnt == 11'd4); c++) @(negedge clk);
        #1;
        n_tests++; if (bus2.busy !== 1'b1 || bus2.out_rgb !== exp2[16:5]) begin n_fail++; $display("FAIL rstblank_inblank busy=%b rgb=%h exp busy=1 rgb=%h", bus2.busy, bus2.out_rgb, exp2[16:5]); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (obs0 !== 43'd0) begin n_fail++; $display("FAIL rstblank_async dut0 got=%h exp=0", obs0); end
        n_tests++; if (obs2 !== 43'd0) begin n_fail++; $display("FAIL rstblank_async dut2 got=%h exp=0", obs2); end
        sel_req = 3'd0;
        @(negedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4 * FRAME; c++) begin
            @(negedge clk); #1;
            n_tests++; if (obs0 !== exp0) begin n_fail++; $display("FAIL rstblank_after dut0 got=%h exp=%h", obs0, exp0); end
            n_tests++; if (obs2 !== exp2) begin n_fail++; $display("FAIL rstblank_after dut2 got=%h exp=%h", obs2, exp2); end
        end
        n_tests++;
        if (bus2.active_sel !== 3'd0 || bus2.busy !== 1'b0 || bus2.out_rgb !== 12'hFFF) begin
            n_fail++;
            $display("FAIL rstblank_final sel=%0d busy=%b rgb=%h exp sel=0 busy=0 rgb=fff",
                     bus2.active_sel, bus2.busy, bus2.out_rgb);
        end
    endtask

    initial begin
        src_col[0] = 12'hF00;
        src_col[1] = 12'h0F0;
        src_col[2] = 12'h00F;
        src_col[3] = 12'h5A5;
        src_col[4] = 12'h3C7;
        test_reset();
        test_direct_switch();
        test_cancel();
        test_invalid();
        test_random();
        test_fade();
        test_reset_mid_blank();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
